// File: rtl/ula_arbiter_if.sv
// Requester, ULA and result bus bundle for ula_arbiter.
// Define ULA_ARB_STATS_EN to add the per-requester op counters.
interface ula_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 8
);
  logic              req0;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic [SEL_W-1:0]  sel0;
  logic              gnt0;
  logic              req1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [SEL_W-1:0]  sel1;
  logic              gnt1;
  logic [DATA_W-1:0] ula_a;
  logic [DATA_W-1:0] ula_b;
  logic [SEL_W-1:0]  ula_sel;
  logic [DATA_W-1:0] ula_out;
  logic              ula_n;
  logic              ula_z;
  logic [DATA_W-1:0] res;
  logic              res_n;
  logic              res_z;
  logic              res_id;
  logic              done;
`ifdef ULA_ARB_STATS_EN
  logic [15:0]       cnt0;
  logic [15:0]       cnt1;
`endif

  modport slave (
    input  req0, a0, b0, sel0,
    input  req1, a1, b1, sel1,
    input  ula_out, ula_n, ula_z,
    output gnt0, gnt1,
    output ula_a, ula_b, ula_sel,
    output res, res_n, res_z, res_id, done
`ifdef ULA_ARB_STATS_EN
    , output cnt0, cnt1
`endif
  );

  modport master (
    output req0, a0, b0, sel0,
    output req1, a1, b1, sel1,
    output ula_out, ula_n, ula_z,
    input  gnt0, gnt1,
    input  ula_a, ula_b, ula_sel,
    input  res, res_n, res_z, res_id, done
`ifdef ULA_ARB_STATS_EN
    , input cnt0, cnt1
`endif
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin two-requester front end for the shared combinational ULA.
// Define ULA_ARB_STATS_EN to add saturating completed-op counters cnt0/cnt1.
module ula_arbiter #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  ula_arbiter_if.slave bus
);
  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state, state_d;
  logic              last_q, last_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              rn_q, rn_d;
  logic              rz_q, rz_d;
  logic              id_q, id_d;
  logic              win;

  always_comb begin
    state_d = state;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    rn_d    = rn_q;
    rz_d    = rz_q;
    id_d    = id_q;
    win     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          // on a tie the requester that did not win last time goes
          win     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
          a_d     = win ? bus.a1 : bus.a0;
          b_d     = win ? bus.b1 : bus.b0;
          sel_d   = win ? bus.sel1 : bus.sel0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          last_d  = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.ula_out;
        rn_d    = bus.ula_n;
        rz_d    = bus.ula_z;
        id_d    = last_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_q <= 1'b1;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      res_q  <= '0;
      rn_q   <= 1'b0;
      rz_q   <= 1'b0;
      id_q   <= 1'b0;
    end else begin
      state  <= state_d;
      last_q <= last_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      done_q <= done_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sel_q  <= sel_d;
      res_q  <= res_d;
      rn_q   <= rn_d;
      rz_q   <= rz_d;
      id_q   <= id_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.done    = done_q;
  assign bus.ula_a   = a_q;
  assign bus.ula_b   = b_q;
  assign bus.ula_sel = sel_q;
  assign bus.res     = res_q;
  assign bus.res_n   = rn_q;
  assign bus.res_z   = rz_q;
  assign bus.res_id  = id_q;

`ifdef ULA_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (done_d) begin
      if (!id_d && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (id_d && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_ula_arbiter.sv
// Scoreboard bench for ula_arbiter with a small ULA model on the bus.
// Define ULA_ARB_STATS_EN to also exercise cnt0/cnt1.
module tb_ula_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        id;
  } exp_t;

  exp_t exp_q[$];
  bit   gq[$];
  exp_t e;
  bit   g;
  logic [31:0] ula_o;

  ula_arbiter_if #(.DATA_W(32), .SEL_W(8)) bus ();

  ula_arbiter #(.DATA_W(32), .SEL_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.ula_sel)
      8'h18:   ula_o = bus.ula_a;
      8'h1A:   ula_o = ~bus.ula_a;
      8'h14:   ula_o = bus.ula_b;
      8'h3C:   ula_o = bus.ula_a + bus.ula_b;
      default: ula_o = 32'h0;
    endcase
  end
  assign bus.ula_out = ula_o;
  assign bus.ula_n   = ula_o[31];
  assign bus.ula_z   = (ula_o == 32'h0);

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gnt0 || bus.gnt1 || bus.done) begin
        checks++;
        if ((bus.gnt0 && bus.gnt1) || (bus.done && (bus.gnt0 || bus.gnt1))) begin
          failures++;
          $display("FAIL excl gnt0=%0b gnt1=%0b done=%0b", bus.gnt0, bus.gnt1, bus.done);
        end
      end
      if (bus.gnt0 || bus.gnt1) begin
        checks++;
        if (gq.size() == 0) begin
          failures++;
          $display("FAIL gnt_unexpected gnt0=%0b gnt1=%0b", bus.gnt0, bus.gnt1);
        end else begin
          g = gq.pop_front();
          if (bus.gnt1 != g || bus.gnt0 != !g) begin
            failures++;
            $display("FAIL gnt_order got gnt0=%0b gnt1=%0b want id=%0b", bus.gnt0, bus.gnt1, g);
          end
        end
      end
      if (bus.done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected res=%h id=%0b", bus.res, bus.res_id);
        end else begin
          e = exp_q.pop_front();
          if (bus.res != e.r || bus.res_n != e.n || bus.res_z != e.z || bus.res_id != e.id) begin
            failures++;
            $display("FAIL result got res=%h n=%0b z=%0b id=%0b want res=%h n=%0b z=%0b id=%0b",
                     bus.res, bus.res_n, bus.res_z, bus.res_id, e.r, e.n, e.z, e.id);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit id);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = id ? bus.gnt1 : bus.gnt0;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL gnt_timeout id=%0b", id);
    end
  endtask

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] sel);
    if (id) begin
      bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.sel1 = sel;
    end else begin
      bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.sel0 = sel;
    end
  endtask

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] sel, input logic [31:0] r,
                       input logic n, input logic z);
    exp_q.push_back('{r: r, n: n, z: z, id: id});
    gq.push_back(id);
    drive(id, a, b, sel);
    wait_gnt(id);
    if (id) bus.req1 = 1'b0;
    else    bus.req0 = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.sel0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.sel1 = '0;
    #2;
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sel", 32'(bus.ula_sel), 0);
    chk("rst_res", bus.res, 0);
    chk("rst_id", 32'(bus.res_id), 0);
    #20;
    rst_n = 1'b1;
    tick(3);
    chk("idle_gnt", 32'({bus.gnt0, bus.gnt1, bus.done}), 0);
    chk("idle_res", bus.res, 0);

    issue(0, 32'd1, 32'd2, 8'h18, 32'd1, 1'b0, 1'b0);
    chk("ula_a", bus.ula_a, 32'd1);
    chk("ula_b", bus.ula_b, 32'd2);
    chk("ula_sel", 32'(bus.ula_sel), 32'h18);
    chk("res_hold", bus.res, 32'd1);

    issue(1, 32'd1, 32'd0, 8'h1A, 32'hFFFF_FFFE, 1'b1, 1'b0);
    issue(1, 32'd0, 32'd0, 8'h14, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      gq.push_back(i[0]);
      if (i[0]) exp_q.push_back('{r: 32'd30, n: 1'b0, z: 1'b0, id: 1'b1});
      else      exp_q.push_back('{r: 32'd7, n: 1'b0, z: 1'b0, id: 1'b0});
    end
    drive(0, 32'd3, 32'd4, 8'h3C);
    drive(1, 32'd10, 32'd20, 8'h3C);
    wait_gnt(0);
    wait_gnt(1);
    wait_gnt(0);
    wait_gnt(1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick(2);

    gq.push_back(1'b0);
    drive(0, 32'd5, 32'd0, 8'h18);
    wait_gnt(0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
    chk("abort_res", bus.res, 0);
    tick(2);
    chk("abort_nodone", 32'(bus.done), 0);
    rst_n = 1'b1;
    tick(1);

    gq.push_back(1'b0);
    gq.push_back(1'b1);
    exp_q.push_back('{r: 32'd7, n: 1'b0, z: 1'b0, id: 1'b0});
    exp_q.push_back('{r: 32'd30, n: 1'b0, z: 1'b0, id: 1'b1});
    drive(0, 32'd3, 32'd4, 8'h3C);
    drive(1, 32'd10, 32'd20, 8'h3C);
    wait_gnt(0);
    bus.req0 = 1'b0;
    wait_gnt(1);
    bus.req1 = 1'b0;
    tick(2);

`ifdef ULA_ARB_STATS_EN
    issue(0, 32'd9, 32'd0, 8'h18, 32'd9, 1'b0, 1'b0);
    issue(0, 32'd0, 32'd0, 8'h14, 32'd0, 1'b0, 1'b1);
    chk("cnt0", 32'(bus.cnt0), 3);
    chk("cnt1", 32'(bus.cnt1), 1);
    force dut.cnt0_q = 16'hFFFF;
    tick(1);
    release dut.cnt0_q;
    issue(0, 32'd2, 32'd0, 8'h18, 32'd2, 1'b0, 1'b0);
    chk("cnt0_sat", 32'(bus.cnt0), 32'hFFFF);
    chk("cnt1_hold", 32'(bus.cnt1), 1);
`endif

    tick(4);
    chk("exp_left", 32'(exp_q.size()), 0);
    chk("gnt_left", 32'(gq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
